// File: rtl/adc_pkt_pkg.sv
// rtl/adc_pkt_pkg.sv - shared types, header layout and header builder for the ADC packetizer
// Purpose: FSM state enums, header geometry and the HDR0 word builder used by
//          adc_multichan_packetizer.
// Ports:   none (package).
package adc_pkt_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE  = 2'd0,
    CAP_ARMED = 2'd1,
    CAP_RUN   = 2'd2
  } cap_state_e;

  typedef enum logic [1:0] {
    PKT_SELECT  = 2'd0,
    PKT_HDR0    = 2'd1,
    PKT_HDR1    = 2'd2,
    PKT_PAYLOAD = 2'd3
  } pkt_state_e;

  localparam int HDR_BEATS = 2;

  localparam int SEQ_LSB   = 32;
  localparam int SEQ_W     = 32;
  localparam int CHAN_LSB  = 24;
  localparam int CHAN_W    = 8;
  localparam int FLAGS_LSB = 16;
  localparam int FLAGS_W   = 8;
  localparam int LEN_LSB   = 0;
  localparam int LEN_W     = 16;

  // HDR0 layout: {seq, chan, flags, payload length in beats}
  function automatic logic [63:0] build_hdr0(input logic [SEQ_W-1:0] seq,
                                             input logic [CHAN_W-1:0] chan,
                                             input logic [LEN_W-1:0] len);
    logic [63:0] w;
    w = '0;
    w[SEQ_LSB +: SEQ_W]     = seq;
    w[CHAN_LSB +: CHAN_W]   = chan;
    w[FLAGS_LSB +: FLAGS_W] = '0;
    w[LEN_LSB +: LEN_W]     = len;
    return w;
  endfunction

endpackage

// File: rtl/rr_chan_select.sv
// rtl/rr_chan_select.sv - combinational round-robin next-enabled-channel finder
// Purpose: returns the first channel after ptr (wrapping, ptr itself last)
//          whose mask bit is set.
// Ports:   ptr       - last served channel
//          mask      - channel enable bits
//          next_chan - selected channel (ptr when none found)
//          found     - at least one mask bit set
module rr_chan_select #(
  parameter int NUM_CHANNELS = 2,
  parameter int CW           = 1
) (
  input  logic [CW-1:0]           ptr,
  input  logic [NUM_CHANNELS-1:0] mask,
  output logic [CW-1:0]           next_chan,
  output logic                    found
);

  int idx;

  // Scan from farthest to nearest so the nearest enabled channel wins.
  always_comb begin
    next_chan = ptr;
    found     = 1'b0;
    idx       = 0;
    for (int i = NUM_CHANNELS; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NUM_CHANNELS;
      if (mask[idx]) begin
        next_chan = CW'(idx);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_multichan_packetizer.sv
// rtl/adc_multichan_packetizer.sv - round-robin multi-channel ADC sample packetizer
// Purpose: frames NUM_CHANNELS sample streams into packets of two header beats
//          plus PAYLOAD_BEATS pass-through payload beats, one packet per
//          enabled channel per turn.
// Ports:   m00_axis_aclk/aresetn     - clock, async active-low reset
//          cfg_enable/start_on_pps   - capture control
//          cfg_chan_mask             - channel enables, sampled at each selection
//          pps_comp                  - synchronous PPS pulse
//          s01_axis_*                - per-channel sample streams
//          m00_axis_*                - packet output stream
//          stat_armed/busy/pkt_count - status
module adc_multichan_packetizer
  import adc_pkt_pkg::*;
#(
  parameter int NUM_CHANNELS  = 2,
  parameter int DATA_WIDTH    = 64,
  parameter int PAYLOAD_BEATS = 128,
  parameter int SEQ_WIDTH     = 32
) (
  input  logic                               m00_axis_aclk,
  input  logic                               m00_axis_aresetn,
  input  logic                               cfg_enable,
  input  logic                               cfg_start_on_pps,
  input  logic [NUM_CHANNELS-1:0]            cfg_chan_mask,
  input  logic                               pps_comp,
  input  logic [NUM_CHANNELS-1:0]            s01_axis_tvalid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s01_axis_tdata,
  output logic [NUM_CHANNELS-1:0]            s01_axis_tready,
  output logic                               m00_axis_tvalid,
  output logic [DATA_WIDTH-1:0]              m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]            m00_axis_tkeep,
  output logic                               m00_axis_tlast,
  output logic                               m00_axis_tuser,
  input  logic                               m00_axis_tready,
  output logic                               stat_armed,
  output logic                               stat_busy,
  output logic [31:0]                        stat_pkt_count
);

  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int BW = $clog2(PAYLOAD_BEATS);

  cap_state_e           cap_state;
  pkt_state_e           pkt_state;
  logic                 enable_q;
  logic                 pps_q;
  logic [SEQ_WIDTH-1:0] seq;
  logic [63:0]          ts [NUM_CHANNELS];
  logic [31:0]          pkt_count;
  logic [CW-1:0]        rr_ptr;
  logic [CW-1:0]        chan;
  logic [BW-1:0]        beat_cnt;
  logic                 hdr_valid;
  logic [DATA_WIDTH-1:0] hdr_data;

  logic [CW-1:0] sel_chan;
  logic          sel_found;
  logic          enable_rise;
  logic          pps_rise;
  logic          hdr_hs;
  logic          pay_hs;
  logic          last_beat;

  rr_chan_select #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .CW           (CW)
  ) u_rr_chan_select (
    .ptr       (rr_ptr),
    .mask      (cfg_chan_mask),
    .next_chan (sel_chan),
    .found     (sel_found)
  );

  assign enable_rise = cfg_enable & ~enable_q;
  // pps_q tracks PPS in every state, so a level already high at arming is not an edge.
  assign pps_rise    = pps_comp & ~pps_q;
  assign hdr_hs      = hdr_valid & m00_axis_tready;
  assign last_beat   = (beat_cnt == BW'(PAYLOAD_BEATS - 1));
  assign pay_hs      = (pkt_state == PKT_PAYLOAD) & s01_axis_tvalid[chan] & m00_axis_tready;

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      cap_state <= CAP_IDLE;
      pkt_state <= PKT_SELECT;
      enable_q  <= 1'b0;
      pps_q     <= 1'b0;
      seq       <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) ts[c] <= '0;
      pkt_count <= '0;
      rr_ptr    <= '0;
      chan      <= '0;
      beat_cnt  <= '0;
      hdr_valid <= 1'b0;
      hdr_data  <= '0;
    end else begin
      enable_q <= cfg_enable;
      pps_q    <= pps_comp;

      case (cap_state)
        CAP_IDLE: begin
          if (enable_rise) begin
            cap_state <= cfg_start_on_pps ? CAP_ARMED : CAP_RUN;
            seq       <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) ts[c] <= '0;
            pkt_count <= '0;
            rr_ptr    <= CW'(NUM_CHANNELS - 1);
          end
        end
        CAP_ARMED: begin
          if (!cfg_enable)   cap_state <= CAP_IDLE;
          else if (pps_rise) cap_state <= CAP_RUN;
        end
        CAP_RUN: begin
          // Stop only between packets; an in-flight packet always completes.
          if (!cfg_enable && pkt_state == PKT_SELECT) cap_state <= CAP_IDLE;
        end
        default: cap_state <= CAP_IDLE;
      endcase

      case (pkt_state)
        PKT_SELECT: begin
          if (cap_state == CAP_RUN && cfg_enable && sel_found) begin
            chan      <= sel_chan;
            rr_ptr    <= sel_chan;
            hdr_valid <= 1'b1;
            hdr_data  <= DATA_WIDTH'(build_hdr0(32'(seq), 8'(sel_chan), 16'(PAYLOAD_BEATS)));
            pkt_state <= PKT_HDR0;
          end
        end
        PKT_HDR0: begin
          if (hdr_hs) begin
            hdr_data  <= DATA_WIDTH'(ts[chan]);
            pkt_state <= PKT_HDR1;
          end
        end
        PKT_HDR1: begin
          if (hdr_hs) begin
            hdr_valid <= 1'b0;
            beat_cnt  <= '0;
            pkt_state <= PKT_PAYLOAD;
          end
        end
        PKT_PAYLOAD: begin
          if (pay_hs) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) begin
              seq       <= seq + 1'b1;
              ts[chan]  <= ts[chan] + 64'(PAYLOAD_BEATS);
              if (pkt_count != 32'hFFFF_FFFF) pkt_count <= pkt_count + 1'b1;
              pkt_state <= PKT_SELECT;
            end
          end
        end
        default: pkt_state <= PKT_SELECT;
      endcase
    end
  end

  // Payload beats bypass registers entirely; headers come from hdr_data.
  always_comb begin
    s01_axis_tready = '0;
    if (pkt_state == PKT_PAYLOAD) begin
      m00_axis_tvalid       = s01_axis_tvalid[chan];
      m00_axis_tdata        = s01_axis_tdata[chan*DATA_WIDTH +: DATA_WIDTH];
      s01_axis_tready[chan] = m00_axis_tready;
    end else begin
      m00_axis_tvalid = hdr_valid;
      m00_axis_tdata  = hdr_data;
    end
  end

  assign m00_axis_tkeep = '1;
  assign m00_axis_tlast = (pkt_state == PKT_PAYLOAD) & last_beat;
  assign m00_axis_tuser = (pkt_state == PKT_HDR0);
  assign stat_armed     = (cap_state == CAP_ARMED);
  assign stat_busy      = (cap_state != CAP_IDLE) | (pkt_state != PKT_SELECT);
  assign stat_pkt_count = pkt_count;

endmodule

// File: tb/tb_adc_multichan_packetizer.sv
// tb/tb_adc_multichan_packetizer.sv - directed self-checking bench for adc_multichan_packetizer
module tb_adc_multichan_packetizer;

  localparam int NCH = 2;
  localparam int DW  = 64;
  localparam int PB  = 4;

  logic            clk = 1'b0;
  logic            resetn;
  logic            cfg_enable;
  logic            cfg_start_on_pps;
  logic [NCH-1:0]  cfg_chan_mask;
  logic            pps_comp;
  logic [NCH-1:0]  s_tvalid;
  logic [NCH*DW-1:0] s_tdata;
  logic [NCH-1:0]  s_tready;
  logic            m_tvalid;
  logic [DW-1:0]   m_tdata;
  logic [DW/8-1:0] m_tkeep;
  logic            m_tlast;
  logic            m_tuser;
  logic            m_tready;
  logic            stat_armed;
  logic            stat_busy;
  logic [31:0]     stat_pkt_count;

  typedef struct {
    logic [63:0] data;
    logic        user;
    logic        last;
  } beat_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  int    src_cnt [NCH];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  adc_multichan_packetizer #(
    .NUM_CHANNELS  (NCH),
    .DATA_WIDTH    (DW),
    .PAYLOAD_BEATS (PB),
    .SEQ_WIDTH     (32)
  ) dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (resetn),
    .cfg_enable       (cfg_enable),
    .cfg_start_on_pps (cfg_start_on_pps),
    .cfg_chan_mask    (cfg_chan_mask),
    .pps_comp         (pps_comp),
    .s01_axis_tvalid  (s_tvalid),
    .s01_axis_tdata   (s_tdata),
    .s01_axis_tready  (s_tready),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tkeep   (m_tkeep),
    .m00_axis_tlast   (m_tlast),
    .m00_axis_tuser   (m_tuser),
    .m00_axis_tready  (m_tready),
    .stat_armed       (stat_armed),
    .stat_busy        (stat_busy),
    .stat_pkt_count   (stat_pkt_count)
  );

  function automatic logic [63:0] src_word(input int c, input int n);
    return {8'(c), 24'h0, 32'(n)};
  endfunction

  function automatic logic [63:0] hdr0(input int s, input int c);
    return {32'(s), 8'(c), 8'h00, 16'(PB)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    s_tdata = {src_word(1, src_cnt[1]), src_word(0, src_cnt[0])};
  endtask

  // Sample at the falling edge, then advance past the rising edge.
  task automatic step();
    logic [NCH-1:0] hs;
    beat_t b;
    @(negedge clk);
    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      b.data = m_tdata;
      b.user = m_tuser;
      b.last = m_tlast;
      got_q.push_back(b);
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) if (hs[c]) src_cnt[c]++;
    drive_src();
  endtask

  task automatic collect(input int n);
    int budget;
    budget = 0;
    while (got_q.size() < n && budget < 300) begin
      step();
      budget++;
    end
    chk("collect_budget", 64'(got_q.size() >= n), 64'(1));
  endtask

  task automatic push_exp(input logic [63:0] d, input logic u, input logic l);
    beat_t b;
    b.data = d;
    b.user = u;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic exp_pkt(input int s, input int c, input int ts, input int first);
    push_exp(hdr0(s, c), 1'b1, 1'b0);
    push_exp(64'(ts), 1'b0, 1'b0);
    for (int i = 0; i < PB; i++) push_exp(src_word(c, first + i), 1'b0, i == PB - 1);
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
      chk($sformatf("%s_user%0d", tag, i), 64'(got_q[i].user), 64'(exp_q[i].user));
      chk($sformatf("%s_last%0d", tag, i), 64'(got_q[i].last), 64'(exp_q[i].last));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn           = 1'b0;
    cfg_enable       = 1'b0;
    cfg_start_on_pps = 1'b0;
    cfg_chan_mask    = 2'b11;
    pps_comp         = 1'b0;
    s_tvalid         = 2'b11;
    m_tready         = 1'b1;
    src_cnt[0]       = 0;
    src_cnt[1]       = 0;
    drive_src();
    #2;
    chk("rst_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_tkeep", 64'(m_tkeep), 64'hFF);
    chk("rst_tlast", 64'(m_tlast), 64'(0));
    chk("rst_tuser", 64'(m_tuser), 64'(0));
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    chk("rst_busy", 64'(stat_busy), 64'(0));
    chk("rst_armed", 64'(stat_armed), 64'(0));
    chk("rst_pkt_count", 64'(stat_pkt_count), 64'(0));
    step();
    step();
    resetn = 1'b1;

    // Immediate start, both channels, always-valid sources
    cfg_enable = 1'b1;
    collect(18);
    exp_pkt(0, 0, 0, 0);
    exp_pkt(1, 1, 0, 0);
    exp_pkt(2, 0, 4, 4);
    compare("imm");

    // Disable at payload beat 2 of 4
    collect(4);
    cfg_enable = 1'b0;
    collect(6);
    exp_pkt(3, 1, 4, 4);
    compare("dis");
    chk("dis_busy_hold", 64'(stat_busy), 64'(1));
    step();
    chk("dis_busy_fall", 64'(stat_busy), 64'(0));
    chk("dis_pkt_count", 64'(stat_pkt_count), 64'(4));
    repeat (3) begin
      step();
      chk("dis_idle_tvalid", 64'(m_tvalid), 64'(0));
    end

    // Arm on PPS while PPS is already high
    pps_comp         = 1'b1;
    cfg_start_on_pps = 1'b1;
    cfg_enable       = 1'b1;
    step();
    chk("pps_armed", 64'(stat_armed), 64'(1));
    chk("pps_count_clr", 64'(stat_pkt_count), 64'(0));
    repeat (5) begin
      step();
      chk("pps_wait_armed", 64'(stat_armed), 64'(1));
      chk("pps_wait_tvalid", 64'(m_tvalid), 64'(0));
    end
    pps_comp = 1'b0;
    step();
    step();
    chk("pps_low_armed", 64'(stat_armed), 64'(1));
    pps_comp = 1'b1;
    step();
    chk("pps_edge1_tvalid", 64'(m_tvalid), 64'(0));
    chk("pps_edge1_armed", 64'(stat_armed), 64'(0));
    step();
    chk("pps_edge2_tvalid", 64'(m_tvalid), 64'(1));
    chk("pps_edge2_tuser", 64'(m_tuser), 64'(1));
    chk("pps_edge2_tdata", m_tdata, hdr0(0, 0));
    step();

    // Backpressure during HDR1
    m_tready = 1'b0;
    repeat (10) begin
      step();
      chk("bp_hdr1_tvalid", 64'(m_tvalid), 64'(1));
      chk("bp_hdr1_tdata", m_tdata, 64'(0));
      chk("bp_hdr1_s_tready", 64'(s_tready), 64'(0));
    end
    m_tready = 1'b1;
    step();
    step();
    step();

    // Backpressure mid-payload (beat 2 waiting)
    m_tready = 1'b0;
    repeat (10) begin
      step();
      chk("bp_pay_tvalid", 64'(m_tvalid), 64'(1));
      chk("bp_pay_tdata", m_tdata, src_word(0, 10));
      chk("bp_pay_s_tready", 64'(s_tready), 64'(0));
    end
    m_tready = 1'b1;
    collect(6);
    exp_pkt(0, 0, 0, 8);
    compare("bp");

    // Only ch1 enabled
    cfg_chan_mask = 2'b10;
    collect(12);
    exp_pkt(1, 1, 0, 8);
    exp_pkt(2, 1, 4, 12);
    compare("mask10");

    // Mask change mid-packet applies at the next selection
    collect(3);
    cfg_chan_mask = 2'b01;
    collect(12);
    exp_pkt(3, 1, 8, 16);
    exp_pkt(4, 0, 4, 12);
    compare("maskchg");

    // Mask zero: running but idle
    cfg_chan_mask = 2'b00;
    repeat (10) begin
      step();
      chk("mask0_tvalid", 64'(m_tvalid), 64'(0));
      chk("mask0_busy", 64'(stat_busy), 64'(1));
    end
    chk("mask0_no_beats", 64'(got_q.size()), 64'(0));
    chk("mask0_pkt_count", 64'(stat_pkt_count), 64'(5));

    // Async reset while the final payload beat is presented
    cfg_chan_mask = 2'b01;
    collect(5);
    chk("rst_pre_tlast", 64'(m_tlast), 64'(1));
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_tvalid", 64'(m_tvalid), 64'(0));
    chk("arst_tlast", 64'(m_tlast), 64'(0));
    chk("arst_s_tready", 64'(s_tready), 64'(0));
    chk("arst_busy", 64'(stat_busy), 64'(0));
    chk("arst_pkt_count", 64'(stat_pkt_count), 64'(0));
    got_q.delete();
    cfg_start_on_pps = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    collect(6);
    exp_pkt(0, 0, 0, 19);
    compare("rst_restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
